// File: rtl/mem_access_unit_if.sv
// CPU load/store request/response plus word-wide memory bus for mem_access_unit.
// slave = the unit; master = whatever drives requests and models memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_enable;
  logic        mem_rw;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_wait;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_wait, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_rw, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_wait, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_rw, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit over a word-only memory bus.
// Sub-word stores are done as read-modify-write with an idle gap between phases.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  addr_lo;
    logic [15:0] wdata;
  } req_t;

  state_t          state;
  req_t            r;
  logic [CW-1:0]   cnt;
  logic            dec_err, done, tmo;
  logic [3:0][7:0] rword, mword;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [31:0]     ext;

  assign dec_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  // cnt==0 is the issue cycle, where mem_wait is not yet meaningful
  assign done = (cnt != '0) && !bus.mem_wait;
  assign tmo  = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    rword = bus.mem_read_data;
    b     = rword[r.addr_lo];
    h     = r.addr_lo[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    case (r.size)
      2'b00:   ext = {{24{b[7] & ~r.uns}}, b};
      2'b01:   ext = {{16{h[15] & ~r.uns}}, h};
      default: ext = bus.mem_read_data;
    endcase
    mword = rword;
    if (r.size == 2'b00)  mword[r.addr_lo]      = r.wdata[7:0];
    else if (r.addr_lo[1]) {mword[3], mword[2]} = r.wdata;
    else                   {mword[1], mword[0]} = r.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      r                  <= '0;
      cnt                <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_err       <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.mem_enable     <= 1'b0;
      bus.mem_rw         <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid && bus.req_ready) begin
          r             <= '{bus.req_we, bus.req_size, bus.req_unsigned,
                             bus.req_addr[1:0], bus.req_wdata[15:0]};
          cnt           <= '0;
          bus.req_ready <= 1'b0;
          if (dec_err) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            bus.mem_enable  <= 1'b1;
            bus.mem_address <= {bus.req_addr[31:2], 2'b00};
            if (bus.req_we && bus.req_size == 2'b10) begin
              state              <= WR;
              bus.mem_rw         <= 1'b1;
              bus.mem_write_data <= bus.req_wdata;
            end else begin
              state      <= RD;
              bus.mem_rw <= 1'b0;
            end
          end
        end
        RD: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            bus.mem_enable <= 1'b0;
            cnt            <= '0;
            if (r.we) begin
              // merged word goes out after a one-cycle enable gap in WR
              state              <= WR;
              bus.mem_rw         <= 1'b1;
              bus.mem_write_data <= mword;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= ext;
            end
          end else if (tmo) begin
            bus.mem_enable <= 1'b0;
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end
        end
        WR: if (!bus.mem_enable) begin
          bus.mem_enable <= 1'b1;
          cnt            <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          if (done || tmo) begin
            bus.mem_enable <= 1'b0;
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= !done;
            bus.resp_rdata <= '0;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit with a word-array memory model
// and a per-request arithmetic reference (lane select, extend, merge, latency).
module tb_mem_access_unit;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();
  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_wr = '0;
  int cur_w = 0;
  int ph_n  = 0;
  int checks = 0;
  int errors = 0;

  // Memory responder: wait is 0 on the issue cycle, then 1 for cur_w cycles.
  always @(negedge clk) begin
    if (bus.mem_enable === 1'b1) ph_n = ph_n + 1;
    else ph_n = 0;
    bus.mem_wait      = (ph_n >= 2) && (ph_n - 1 <= cur_w);
    bus.mem_read_data = mem[bus.mem_address[7:2]];
  end

  always @(posedge clk)
    if (bus.mem_enable === 1'b1 && bus.mem_rw === 1'b1 && bus.mem_wait === 1'b0 && ph_n >= 2) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
      last_wr                   <= bus.mem_write_data;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd, input int w,
                                  output logic err, output logic [31:0] rd, output int lat);
    int nb, sh, p;
    logic [31:0] word, mask, v;
    logic [5:0] idx;
    idx  = a[7:2];
    word = ref_mem[idx];
    sh   = 8 * int'(a[1:0]);
    err  = 1'b0;
    rd   = '0;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
      err = 1'b1; lat = 1; return;
    end
    p   = (w + 2 < TIMEOUT) ? w + 2 : TIMEOUT;
    lat = 1 + p;
    if (w + 2 > TIMEOUT) begin err = 1'b1; return; end
    nb   = 1 << sz;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (!we) begin
      v = (word >> sh) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      rd = v;
    end else if (nb == 4) begin
      ref_mem[idx] = wd;
    end else begin
      lat = lat + 1 + p;
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endfunction

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int w);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send.ready_timeout", bus.req_ready, 1'b1);
    cur_w = w;
    drive(we, sz, uns, a, wd);
    @(posedge clk);
  endtask

  task automatic collect(input string tag, input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_lat, output logic [31:0] obs_rd);
    int lat = 0;
    logic en_seen = 1'b0, addr_bad = 1'b0, rdy_early = 1'b0, got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk); lat++;
      if (bus.mem_enable === 1'b1) begin
        en_seen = 1'b1;
        if (bus.mem_address[1:0] !== 2'b00) addr_bad = 1'b1;
      end
      if (bus.resp_valid === 1'b1) got = 1'b1;
      else if (bus.req_ready !== 1'b0) rdy_early = 1'b1;
    end
    obs_rd = bus.resp_rdata;
    chk($sformatf("%s.resp_valid", tag), got, 1'b1);
    chk($sformatf("%s.latency", tag), lat, exp_lat);
    chk($sformatf("%s.resp_err", tag), bus.resp_err, exp_err);
    chk($sformatf("%s.resp_rdata", tag), bus.resp_rdata, exp_rd);
    chk($sformatf("%s.ready_busy", tag), {bus.req_ready, rdy_early}, 2'b00);
    chk($sformatf("%s.addr_align", tag), addr_bad, 1'b0);
    if (exp_lat == 1) chk($sformatf("%s.no_enable", tag), en_seen, 1'b0);
    @(negedge clk);
    chk($sformatf("%s.pulse", tag), {bus.resp_valid, bus.req_ready}, 2'b01);
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int w,
                     output logic [31:0] obs_rd);
    logic e;
    logic [31:0] r;
    int l;
    predict(we, sz, uns, a, wd, w, e, r, l);
    send(we, sz, uns, a, wd, w);
    #1 bus.req_valid = 1'b0;
    collect(tag, e, r, l, obs_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic ea, eb;
    logic [31:0] ra, rb;
    int la, lb, n, nbad;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[6'h20] = 32'h8899_AABB;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    bus.mem_wait = 1'b0;
    bus.mem_read_data = '0;
    drive(1'b0, 2'b00, 1'b0, '0, '0);
    bus.req_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", bus.req_ready, 1'b1);
    chk("reset.resp", {bus.resp_valid, bus.resp_err, bus.mem_enable, bus.mem_rw}, 4'b0000);
    chk("reset.resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset.mem_address", bus.mem_address, 32'h0);
    chk("reset.mem_write_data", bus.mem_write_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run("ldb_signed", 1'b0, 2'b00, 1'b0, 32'h81, 32'h0, 0, rd);
    chk("ldb_signed.value", rd, 32'hFFFF_FFAA);

    run("sth_rmw", 1'b1, 2'b01, 1'b0, 32'h82, 32'h1234, 0, rd);
    chk("sth_rmw.write_data", last_wr, 32'h1234_AABB);
    run("ldw_after", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1, rd);
    chk("ldw_after.value", rd, 32'h1234_AABB);

    run("ldw_misalign", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, rd);

    run("timeout", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1000, rd);
    chk("timeout.enable_after", bus.mem_enable, 1'b0);

    // Back-to-back: valid held high, fields switch to B right after A is accepted.
    predict(1'b0, 2'b00, 1'b1, 32'h83, 32'h0, 1, ea, ra, la);
    predict(1'b1, 2'b10, 1'b0, 32'h84, 32'hCAFE_F00D, 2, eb, rb, lb);
    send(1'b0, 2'b00, 1'b1, 32'h83, 32'h0, 1);
    #1 drive(1'b1, 2'b10, 1'b0, 32'h84, 32'hCAFE_F00D);
    collect("b2b_a", ea, ra, la, rd);
    cur_w = 2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    collect("b2b_b", eb, rb, lb, rd);
    run("b2b_check", 1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 0, rd);

    // Reset during the WR phase of a read-modify-write.
    send(1'b1, 2'b00, 1'b0, 32'h44, 32'h5A, 3);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.mem_enable === 1'b1 && bus.mem_rw === 1'b1) && n < 40);
    chk("rst_wr.reached", {bus.mem_enable, bus.mem_rw}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wr.mem_enable", bus.mem_enable, 1'b0);
    chk("rst_wr.resp_valid", bus.resp_valid, 1'b0);
    chk("rst_wr.req_ready", bus.req_ready, 1'b1);
    rst_n = 1'b1;
    ea = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.resp_valid !== 1'b0) ea = 1'b1; end
    chk("rst_wr.no_resp", ea, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      int w;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 10) : $urandom_range(0, 4);
      run($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          a, $urandom, w, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    nbad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("final.mem_words_differing", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for mem_wait low per memory phase.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, CPU load/store request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 0=load, 1=store.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1: 1 zero-extends loads, 0 sign-extends them.
REQ-009 SHALL have port req_addr, input, 32, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned in bits [7:0], [15:0] or [31:0].
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1, misaligned, illegal-size or timeout; valid with resp_valid.
REQ-014 SHALL have port mem_enable, output, 1, memory select.
REQ-015 SHALL have port mem_rw, output, 1: 0=read, 1=write.
REQ-016 SHALL have port mem_address, output, 32, word-aligned address (bits [1:0]=00).
REQ-017 SHALL have port mem_write_data, output, 32, full word to write.
REQ-018 SHALL have port mem_wait, input, 1, memory busy.
REQ-019 SHALL have port mem_read_data, input, 32, memory read word.

Function
REQ-020 SHALL implement states IDLE, RD, WR and RESP; req_ready=1 only in IDLE; a request is accepted on a posedge with req_valid&&req_ready, and all request fields are captured.
REQ-021 SHALL decode an error on accept (size 11; halfword with addr[0]=1; word with addr[1:0]!=00), go to RESP with resp_err=1, and never assert mem_enable for that request.
REQ-022 SHALL, on an accepted load or a byte/halfword store, go to RD; on a word store, go to WR.
REQ-023 SHALL keep mem_enable=1 with mem_rw, mem_address and mem_write_data stable throughout RD and WR; all mem_* outputs are registered.
REQ-024 SHALL ignore mem_wait in the first cycle of each phase (issue cycle); the phase then completes on the first later cycle with mem_wait=0.
REQ-025 SHALL sample mem_read_data on RD completion.
REQ-026 SHALL drop mem_enable for at least one cycle between the RD and WR phases of a read-modify-write.
REQ-027 SHALL, for byte/halfword stores, move from RD to WR with mem_write_data equal to the read word, with only the lane at addr[1:0] (byte) or addr[1] (halfword) replaced by req_wdata.
REQ-028 SHALL, for loads, select the lane at addr[1:0] (little-endian), extend it per req_unsigned, and go RD->RESP.
REQ-029 SHALL count cycles per phase; if the count reaches TIMEOUT with mem_wait still 1, it drops mem_enable, aborts the phase (no WR for RMW) and goes to RESP with resp_err=1.
REQ-030 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE; resp_valid and req_ready are never both 1.
REQ-031 SHALL ignore req_valid in all states other than IDLE.
REQ-032 SHALL have latency from accept edge to resp_valid of 1 cycle for errors, and 1 + phase cycles (+1 gap for RMW) otherwise.

Reset
REQ-033 SHALL, with rst_n=0 at a posedge, enter IDLE, clear counters, and set req_ready=1; resp_valid, resp_err, mem_enable and mem_rw=0; resp_rdata, mem_address and mem_write_data=0.
REQ-034 SHALL, on reset mid-phase, abandon the transfer: mem_enable=0 on the next cycle and no resp_valid for the aborted request.

Verification
REQ-035 SHALL verify: memory word 0x80 = 0x8899AABB; load byte, signed, addr 0x81 -> resp_rdata=0xFFFFFFAA, resp_err=0.
REQ-036 SHALL verify: same word; halfword store 0x1234 to 0x82 -> RD then WR, mem_write_data=0x1234AABB, resp_err=0; a subsequent word load of 0x80 returns 0x1234AABB.
REQ-037 SHALL verify: word load at 0x102 -> resp_err=1 one cycle after accept, mem_enable never 1.
REQ-038 SHALL verify: mem_wait held 1 permanently, TIMEOUT=8 -> resp_err=1 after 8 phase cycles, mem_enable then 0.
REQ-039 SHALL verify: rst_n=0 during WR of an RMW -> mem_enable=0 the next cycle, no resp_valid, req_ready=1.
REQ-040 SHALL verify: back-to-back req_valid held high -> the second request is accepted only after resp_valid of the first, and is captured with its own fields.
